expr_sweep_checker: RTL and testbench

Exhaustive stimulus driver and response checker for the eight-output precedence/negation expression block. It sits on both sides of that block. It drives every combination of the four inputs `{a,b,c,d}` and waits a programmable settle time. It then samples the eight outputs, compares them against a built-in golden model, and reports the mismatch count, the first failing vector, and pass/fail.

---
 rtl/expr_sweep_pkg.sv | 23 ++
 rtl/expr_sweep_checker.sv | 137 +++++++++++++
 tb/tb_expr_sweep_checker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/expr_sweep_pkg.sv
// expr_sweep_pkg: shared types, sizes and golden model for the expression sweep checker
package expr_sweep_pkg;

    localparam int VEC_W   = 4;
    localparam int RESP_W  = 8;
    localparam int NUM_VEC = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    // Reference outputs of the precedence/negation block; v = {a,b,c,d}, result bit 0 = out1
    function automatic logic [RESP_W-1:0] expr_golden(input logic [VEC_W-1:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return {~((a & b) | c), (a & b) | (c & d), a & (b | c), (a | b) & c,
                (a & b) | c, a | (b & c), a & c, a | b};
    endfunction

endpackage

// File: rtl/expr_sweep_checker.sv
// expr_sweep_checker: drives all 16 {a,b,c,d} vectors, waits a settle time, checks the
// eight responses against the golden model and reports errors. Optional macro
// EXPR_SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module expr_sweep_checker
    import expr_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [VEC_W-1:0]     vec,
    input  logic [RESP_W-1:0]    resp,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_err_valid,
    output logic [VEC_W-1:0]     first_err_vec,
    output logic [RESP_W-1:0]    first_err_mask,
    output logic                 pass
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0]           CNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0]     LAST_VEC = VEC_W'(NUM_VEC - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    sweep_state_t          r_state, w_state;
    logic [3:0]            r_cnt, w_cnt;
    logic [VEC_W-1:0]      r_vec, w_vec;
    logic [ERR_CNT_W-1:0]  r_err, w_err;
    logic                  r_fv, w_fv;
    logic [VEC_W-1:0]      r_fvec, w_fvec;
    logic [RESP_W-1:0]     r_fmask, w_fmask;
    logic                  r_pass, w_pass;
    logic                  r_busy, r_done;
    logic [RESP_W-1:0]     w_diff;
    logic                  w_mism;

    assign w_diff = resp ^ expr_golden(r_vec);
    assign w_mism = |w_diff;

    // State and datapath registers; busy/done are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_err   <= '0;
            r_fv    <= 1'b0;
            r_fvec  <= '0;
            r_fmask <= '0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_vec   <= w_vec;
            r_err   <= w_err;
            r_fv    <= w_fv;
            r_fvec  <= w_fvec;
            r_fmask <= w_fmask;
            r_pass  <= w_pass;
            r_busy  <= (w_state != IDLE);
            r_done  <= (w_state == DONE);
        end
    end

    // Sweep sequencing, error counting and first-mismatch capture
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_vec   = r_vec;
        w_err   = r_err;
        w_fv    = r_fv;
        w_fvec  = r_fvec;
        w_fmask = r_fmask;
        w_pass  = r_pass;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state = SETTLE;
                    w_cnt   = '0;
                    w_vec   = '0;
                    w_err   = '0;
                    w_fv    = 1'b0;
                    w_fvec  = '0;
                    w_fmask = '0;
                    w_pass  = 1'b0;
                end
            end
            SETTLE: begin
                w_state = (r_cnt == CNT_LAST) ? CHECK : SETTLE;
                w_cnt   = (r_cnt == CNT_LAST) ? r_cnt : r_cnt + 4'd1;
            end
            CHECK: begin
                if (w_mism) begin
                    w_err = (r_err == ERR_MAX) ? r_err : r_err + 1'b1;
                    if (!r_fv) begin
                        w_fv    = 1'b1;
                        w_fvec  = r_vec;
                        w_fmask = w_diff;
                    end
                end
`ifdef EXPR_SWEEP_STOP_ON_ERR_EN
                if (r_vec == LAST_VEC || w_mism) begin
`else
                if (r_vec == LAST_VEC) begin
`endif
                    w_state = DONE;
                    w_pass  = (w_err == '0);
                end else begin
                    w_state = SETTLE;
                    w_vec   = r_vec + 1'b1;
                    w_cnt   = '0;
                end
            end
            DONE:    w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end

    assign vec             = r_vec;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err_count       = r_err;
    assign first_err_valid = r_fv;
    assign first_err_vec   = r_fvec;
    assign first_err_mask  = r_fmask;
    assign pass            = r_pass;

endmodule

// File: tb/tb_expr_sweep_checker.sv
// tb_expr_sweep_checker: directed sweeps with a behavioural responder and hand-computed results
module tb_expr_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] vec, vec2;
    logic [7:0] resp, resp2;
    logic       busy, done, fv, pass;
    logic [4:0] err;
    logic [3:0] fvec;
    logic [7:0] fmask;
    logic       busy2, done2, fv2, pass2;
    logic [2:0] err2;
    logic [3:0] fvec2;
    logic [7:0] fmask2;
    int         mode = 0;
    int         checks = 0;
    int         errors = 0;
    int         n;

    always #5 clk = ~clk;

    expr_sweep_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vec), .resp(resp),
        .busy(busy), .done(done), .err_count(err), .first_err_valid(fv),
        .first_err_vec(fvec), .first_err_mask(fmask), .pass(pass)
    );

    expr_sweep_checker #(.SETTLE_CYCLES(1), .ERR_CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .vec(vec2), .resp(resp2),
        .busy(busy2), .done(done2), .err_count(err2), .first_err_valid(fv2),
        .first_err_vec(fvec2), .first_err_mask(fmask2), .pass(pass2)
    );

    function automatic logic [7:0] tb_gold(input logic [3:0] v);
        logic a, b, c, d;
        logic [7:0] o;
        {a, b, c, d} = v;
        o[0] = a | b;
        o[1] = a & c;
        o[2] = a | (b & c);
        o[3] = (a & b) | c;
        o[4] = (a | b) & c;
        o[5] = a & (b | c);
        o[6] = (a & b) | (c & d);
        o[7] = ~((a & b) | c);
        return o;
    endfunction

    always_comb begin
        resp = tb_gold(vec);
        if (mode == 1) resp[7] = 1'b0;
        if (mode == 2 && vec == 4'h8) resp = 8'h84;
        if (mode == 3 && vec == 4'h5) resp = tb_gold(vec) ^ 8'h10;
        resp2 = ~tb_gold(vec2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start, optionally pulses it again mid-sweep, returns the cycle done was seen
    task automatic sweep(input int pulse_at, output int cyc);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        chk("busy_c1", 32'(busy), 32'd1);
        chk("vec_c1", 32'(vec), 32'd0);
        while (!done && cyc < 200) begin
            start = (cyc == pulse_at);
            @(posedge clk);
            #1 cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vec", 32'(vec), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_fv", 32'(fv), 32'd0);
        chk("rst_fmask", 32'(fmask), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`ifdef EXPR_SWEEP_STOP_ON_ERR_EN
        mode = 3;
        sweep(-1, n);
        chk("stop_done_cycle", 32'(n), 32'd13);
        chk("stop_err", 32'(err), 32'd1);
        chk("stop_vec", 32'(vec), 32'd5);
        chk("stop_pass", 32'(pass), 32'd0);
        chk("stop_fvec", 32'(fvec), 32'd5);
        chk("stop_fmask", 32'(fmask), 32'h10);
`else
        mode = 0;
        sweep(-1, n);
        chk("good_done_cycle", 32'(n), 32'd33);
        chk("good_err", 32'(err), 32'd0);
        chk("good_pass", 32'(pass), 32'd1);
        chk("good_fv", 32'(fv), 32'd0);
        chk("good_vec_hold", 32'(vec), 32'd15);
        chk("good_busy_idle", 32'(busy), 32'd0);
        chk("good_done_pulse", 32'(done), 32'd0);
        chk("sat_err", 32'(err2), 32'd7);
        chk("sat_fv", 32'(fv2), 32'd1);
        chk("sat_fvec", 32'(fvec2), 32'd0);
        chk("sat_fmask", 32'(fmask2), 32'hFF);
        chk("sat_pass", 32'(pass2), 32'd0);

        mode = 1;
        sweep(-1, n);
        chk("stuck_err", 32'(err), 32'd6);
        chk("stuck_fv", 32'(fv), 32'd1);
        chk("stuck_fvec", 32'(fvec), 32'h0);
        chk("stuck_fmask", 32'(fmask), 32'h80);
        chk("stuck_pass", 32'(pass), 32'd0);

        mode = 2;
        sweep(-1, n);
        chk("v8_err", 32'(err), 32'd1);
        chk("v8_fvec", 32'(fvec), 32'h8);
        chk("v8_fmask", 32'(fmask), 32'h01);
        chk("v8_pass", 32'(pass), 32'd0);

        mode = 0;
        sweep(10, n);
        chk("midstart_done_cycle", 32'(n), 32'd33);
        chk("midstart_pass", 32'(pass), 32'd1);

        mode = 1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (vec != 4'd7 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("reach_vec7", 32'(vec), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("arst_vec", 32'(vec), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_fv", 32'(fv), 32'd0);
        chk("arst_fvec", 32'(fvec), 32'd0);
        chk("arst_fmask", 32'(fmask), 32'd0);
        chk("arst_pass", 32'(pass), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        sweep(-1, n);
        chk("post_rst_done_cycle", 32'(n), 32'd33);
        chk("post_rst_err", 32'(err), 32'd6);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
